// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-fetch path.
package mips_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_WORD_DEF = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] data;
      logic [XLEN-1:0] addr;
      logic            err;
   } rsp_t;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response handshake bundle between a core and the instruction store.
interface imem_responder_if;
   import mips_pkg::*;

   logic            req_valid;
   logic [XLEN-1:0] req_addr;
   logic            req_ready;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_data;
   logic [XLEN-1:0] rsp_addr;
   logic            rsp_err;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
   );

endinterface

// File: rtl/rsp_fifo2.sv
// Two-entry fall-through response FIFO; an input presented while empty is visible on the
// output in the same cycle, so the read stage adds no extra bubble.
module rsp_fifo2
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  rsp_t       in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output rsp_t       out_data,
   output logic [1:0] count
);

   rsp_t       mem_q [2];
   logic       rd_ptr_q, wr_ptr_q;
   logic [1:0] cnt_q, cnt_d;
   logic       empty, full, bypass, push_store, pop_store;

   always_comb begin
      empty      = (cnt_q == 2'd0);
      full       = (cnt_q == 2'd2);
      out_valid  = !empty || in_valid;
      out_data   = empty ? in_data : mem_q[rd_ptr_q];
      in_ready   = !full || out_ready;
      // Consumed straight through without ever touching storage
      bypass     = empty && in_valid && out_ready;
      push_store = in_valid && in_ready && !bypass;
      pop_store  = out_valid && out_ready && !empty;
      cnt_d      = cnt_q + {1'b0, push_store} - {1'b0, pop_store};
      count      = cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (push_store) begin
            mem_q[wr_ptr_q] <= in_data;
            wr_ptr_q        <= !wr_ptr_q;
         end
         if (pop_store) rd_ptr_q <= !rd_ptr_q;
      end
   end

endmodule

// File: rtl/imem_responder.sv
// Instruction store with a valid/ready fetch port: synchronous-read array, one-deep read
// stage and a two-entry response FIFO, returning responses in acceptance order.
module imem_responder
   import mips_pkg::*;
#(
   parameter int unsigned     AW       = 8,
   parameter logic [XLEN-1:0] NOP_WORD = NOP_WORD_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   imem_responder_if.slave     bus,
   input  logic                ld_en,
   input  logic [AW-1:0]       ld_addr,
   input  logic [XLEN-1:0]     ld_data
);

   localparam int unsigned Depth = 2 ** AW;

   logic [XLEN-1:0] mem [Depth];
   logic [XLEN-1:0] rd_data_q;

   logic            rs_valid_q;
   logic [XLEN-1:0] rs_addr_q;
   logic            rs_err_q;

   logic [XLEN-1:0] hi_bits;
   logic [AW-1:0]   rd_idx;
   logic            req_err, accept, rd_en, rs_adv, fifo_pop;
   logic            fifo_in_ready, rsp_valid;
   logic [1:0]      fifo_cnt;
   rsp_t            rs_rsp, fifo_out;

   always_comb begin
      hi_bits  = bus.req_addr >> (AW + 2);
      req_err  = (bus.req_addr[1:0] != 2'b00) || (hi_bits != '0);
      rd_idx   = bus.req_addr[AW+1:2];
      fifo_pop = rsp_valid && bus.rsp_ready;
      // Always true under the two-outstanding bound; keeps the stage lossless regardless
      rs_adv   = !rs_valid_q || fifo_in_ready;
      bus.req_ready = ((({1'b0, rs_valid_q} + fifo_cnt) < 2'd2) || fifo_pop) && rs_adv;
      accept   = bus.req_valid && bus.req_ready;
      rd_en    = accept && !req_err;
      rs_rsp   = '0;
      if (rs_valid_q) begin
         rs_rsp.data = rs_err_q ? NOP_WORD : rd_data_q;
         rs_rsp.addr = rs_addr_q;
         rs_rsp.err  = rs_err_q;
      end
   end

   // Non-blocking read and write give read-before-write on a same-word collision
   always_ff @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      if (rd_en) rd_data_q <= mem[rd_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs_valid_q <= 1'b0;
         rs_addr_q  <= '0;
         rs_err_q   <= 1'b0;
      end else if (rs_adv) begin
         rs_valid_q <= accept;
         rs_addr_q  <= bus.req_addr;
         rs_err_q   <= req_err;
      end
   end

   rsp_fifo2 u_rsp_fifo2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rs_valid_q),
      .in_ready  (fifo_in_ready),
      .in_data   (rs_rsp),
      .out_valid (rsp_valid),
      .out_ready (bus.rsp_ready),
      .out_data  (fifo_out),
      .count     (fifo_cnt)
   );

   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_data  = fifo_out.data;
   assign bus.rsp_addr  = fifo_out.addr;
   assign bus.rsp_err   = fifo_out.err;

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter AW, default 8, word-address width of instruction store (2^AW 32-bit words).
REQ-002 SHALL have parameter NOP_WORD, default 32'h0000_0000, data returned on error responses.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, fetch request present.
REQ-006 SHALL have port req_addr, input, 32, byte address of the instruction to fetch.
REQ-007 SHALL have port req_ready, output, 1, request accepted when req_valid and req_ready are both high on a rising edge.
REQ-008 SHALL have port rsp_valid, output, 1, response present.
REQ-009 SHALL have port rsp_ready, input, 1, response consumed when rsp_valid and rsp_ready are both high on a rising edge.
REQ-010 SHALL have port rsp_data, output, 32, instruction word.
REQ-011 SHALL have port rsp_addr, output, 32, echo of the request byte address.
REQ-012 SHALL have port rsp_err, output, 1, request was misaligned or out of range.
REQ-013 SHALL have port ld_en, input, 1, program-load write strobe.
REQ-014 SHALL have port ld_addr, input, AW, load word address.
REQ-015 SHALL have port ld_data, input, 32, load word.

Function
REQ-016 SHALL store instructions in a synchronous-read array of 2^AW words, written when ld_en is high, one word per cycle.
REQ-017 SHALL read the array on request acceptance; the response SHALL be presented no earlier than 1 cycle after acceptance.
REQ-018 SHALL pass each accepted request through a 1-deep read stage (valid, addr, err) into a 2-entry response FIFO.
REQ-019 SHALL drive req_ready high iff (read-stage occupancy + FIFO occupancy) < 2, or a FIFO pop occurs in the same cycle.
REQ-020 SHALL sustain 1 request per cycle while rsp_ready stays high.
REQ-021 SHALL flag rsp_err when req_addr[1:0] != 0 or req_addr[31:AW+2] != 0; rsp_data SHALL then equal NOP_WORD and the array SHALL NOT be read.
REQ-022 SHALL return responses strictly in acceptance order.
REQ-023 SHALL hold rsp_valid, rsp_data, rsp_addr and rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-024 SHALL, on simultaneous FIFO push and pop, keep occupancy unchanged.
REQ-025 SHALL, when ld_en and an accepted request target the same word in the same cycle, return the old word (read-before-write).
REQ-026 SHALL accept address 32'hFFFF_FFFC and flag it as out of range without wrap-around aliasing.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear the read-stage valid, FIFO pointers and occupancy; rsp_valid=0, rsp_err=0, rsp_data=0, rsp_addr=0, req_ready=1 after release.
REQ-028 SHALL discard in-flight requests when reset asserts mid-operation; array contents are not cleared.

Structure
REQ-029 SHALL place NOP_WORD default and the response record field widths in a shared mips_pkg package.
REQ-030 SHALL implement the response FIFO as sub-module rsp_fifo2 (2-entry, valid/ready both sides).

Verification
REQ-031 SHALL cover: load word 3 = 32'h2008_0005; request 32'h0000_000C -> next cycle rsp_valid=1, rsp_data=32'h2008_0005, rsp_err=0.
REQ-032 SHALL cover: request 32'h0000_0006 -> rsp_err=1, rsp_data=NOP_WORD, rsp_addr=32'h0000_0006.
REQ-033 SHALL cover: request 32'hFFFF_FFFC with AW=8 -> rsp_err=1.
REQ-034 SHALL cover: rsp_ready=0, 3 back-to-back requests -> req_ready=0 after 2 accepts; outputs stable; release -> 3 in-order responses.
REQ-035 SHALL cover: streaming addresses 0,4,8,... with rsp_ready=1 -> one response per cycle, no bubbles.
REQ-036 SHALL cover: rst_n low with 2 responses pending -> rsp_valid=0 immediately, no stale response after release.
